// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and IMEM write port of the instruction
// memory loader.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// IMEM loader: length-prefixed LE byte stream into one-cycle IMEM word writes,
// XOR-verified, with an inter-byte watchdog; holds the core while loading.
module imem_loader #(
    parameter int          IMEM_DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_error,
    output logic [15:0]   words_written
);
    typedef enum logic [2:0] {
        IDLE, LEN, DATA, CHK, DONE, ERR
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] sreg;
    logic [31:0] len;
    logic [31:0] word_idx;
    logic [31:0] timer;
    logic [7:0]  csum;
    logic        acc;
    logic        timeout;
    logic        last_byte;
    logic [31:0] shifted;

    assign acc       = bus.rx_valid && bus.rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    // Length and payload words share one LE shift register.
    assign shifted   = {bus.rx_data, sreg[31:8]};
    assign timeout   = bus.rx_ready &&
                       (timer == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            byte_cnt       <= 2'd0;
            sreg           <= 32'd0;
            len            <= 32'd0;
            word_idx       <= 32'd0;
            timer          <= 32'd0;
            csum           <= 8'd0;
            core_hold      <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            words_written  <= 16'd0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= 32'd0;
            bus.imem_wdata <= 32'd0;
        end else begin
            bus.imem_we <= 1'b0;
            if (timeout) begin
                state        <= ERR;
                load_error   <= 1'b1;
                bus.rx_ready <= 1'b0;
            end else if (acc) begin
                timer    <= 32'd0;
                byte_cnt <= byte_cnt + 2'd1;
                sreg     <= shifted;
                unique case (state)
                    LEN: begin
                        if (last_byte) begin
                            if (shifted == 32'd0 ||
                                shifted > 32'(IMEM_DEPTH)) begin
                                state        <= ERR;
                                load_error   <= 1'b1;
                                bus.rx_ready <= 1'b0;
                            end else begin
                                len   <= shifted;
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        csum <= csum ^ bus.rx_data;
                        if (last_byte) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= BASE_ADDR +
                                              {word_idx[29:0], 2'b00};
                            bus.imem_wdata <= shifted;
                            word_idx       <= word_idx + 32'd1;
                            words_written  <= words_written + 16'd1;
                            if (word_idx + 32'd1 == len)
                                state <= CHK;
                        end
                    end
                    CHK: begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state      <= ERR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (bus.rx_ready) begin
                timer <= timer + 32'd1;
            end else if (start && (state == IDLE ||
                                   state == DONE ||
                                   state == ERR)) begin
                state         <= LEN;
                byte_cnt      <= 2'd0;
                word_idx      <= 32'd0;
                csum          <= 8'd0;
                timer         <= 32'd0;
                words_written <= 16'd0;
                load_done     <= 1'b0;
                load_error    <= 1'b0;
                core_hold     <= 1'b1;
                bus.rx_ready  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good image, bad checksum, length limits,
// paced stream, watchdog, mid-load reset and start handling.
module tb_imem_loader;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_written;
    int          total = 0;
    int          bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader_if bus ();

    imem_loader #(
        .IMEM_DEPTH    (256),
        .BASE_ADDR     (32'h0),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_we) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) check("rdy_wait", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_img(input logic [7:0] chk, input int maxgap);
        logic [7:0] img [12];
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00,
                8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 12; i++)
            send(img[i], $urandom_range(0, maxgap));
        send(chk, $urandom_range(0, maxgap));
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nw"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0);
            check({tag, "_d0"}, wd[0], 32'h00000013);
            check({tag, "_a1"}, wa[1], 32'h4);
            check({tag, "_d1"}, wd[1], 32'h00100093);
        end
    endtask

    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_hold", 32'(core_hold), 32'd0);
        check("rst_flags", {30'd0, load_done, load_error}, 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // good image
        pulse_start();
        check("t1_hold", 32'(core_hold), 32'd1);
        check("t1_rdy", 32'(bus.rx_ready), 32'd1);
        send_img(8'h90, 0);
        check_two_writes("t1");
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_err", 32'(load_error), 32'd0);
        check("t1_hold2", 32'(core_hold), 32'd0);
        check("t1_ww", 32'(words_written), 32'd2);
        check("t1_rdy2", 32'(bus.rx_ready), 32'd0);
        check("t1_hwd", bus.imem_wdata, 32'h00100093);

        // bad checksum
        wa.delete(); wd.delete();
        pulse_start();
        send_img(8'h91, 0);
        check_two_writes("t2");
        check("t2_err", 32'(load_error), 32'd1);
        check("t2_done", 32'(load_done), 32'd0);
        check("t2_hold", 32'(core_hold), 32'd1);
        check("t2_ww", 32'(words_written), 32'd2);

        // zero length
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'h00, 0);
        check("t3z_err", 32'(load_error), 32'd1);
        check("t3z_rdy", 32'(bus.rx_ready), 32'd0);
        check("t3z_hold", 32'(core_hold), 32'd1);

        // length 257
        pulse_start();
        send(8'h01, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
        check("t3b_err", 32'(load_error), 32'd1);
        check("t3b_rdy", 32'(bus.rx_ready), 32'd0);
        check("t3_nw", 32'(wa.size()), 32'd0);

        // length 256 is legal
        pulse_start();
        send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
        check("t3m_err", 32'(load_error), 32'd0);
        check("t3m_rdy", 32'(bus.rx_ready), 32'd1);

        // paced stream
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wa.delete(); wd.delete();
        pulse_start();
        send_img(8'h90, 5);
        check_two_writes("t4");
        check("t4_done", 32'(load_done), 32'd1);

        // watchdog
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h00, 0);
        check("t4w_err0", 32'(load_error), 32'd0);
        n = 0;
        while (!load_error && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        check("t4w_cyc", 32'(n), 32'(TMO));
        check("t4w_rdy", 32'(bus.rx_ready), 32'd0);
        check("t4w_nw", 32'(wa.size()), 32'd0);

        // mid-load reset
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h93, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rdy", 32'(bus.rx_ready), 32'd0);
        check("t5_hold", 32'(core_hold), 32'd0);
        check("t5_ww", 32'(words_written), 32'd0);
        check("t5_we", 32'(bus.imem_we), 32'd0);
        rst = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h00;
        repeat (6) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("t5_nw", 32'(wa.size()), 32'd1);
        check("t5_idle", {30'd0, load_done, load_error}, 32'd0);

        // start ignored in DATA
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h00, 0);
        pulse_start();
        send(8'h00, 0); send(8'h00, 0);
        send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
        send(8'h90, 0);
        check_two_writes("t6");
        check("t6_done", 32'(load_done), 32'd1);

        // start from DONE
        wa.delete(); wd.delete();
        pulse_start();
        check("t6s_done", 32'(load_done), 32'd0);
        check("t6s_err", 32'(load_error), 32'd0);
        check("t6s_hold", 32'(core_hold), 32'd1);
        check("t6s_ww", 32'(words_written), 32'd0);
        check("t6s_rdy", 32'(bus.rx_ready), 32'd1);
        send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
        send(8'h22, 0);
        check("t6s_nw", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t6s_a0", wa[0], 32'h0);
            check("t6s_d0", wd[0], 32'hDEADBEEF);
        end
        check("t6s_fin", 32'(load_done), 32'd1);
        check("t6s_ww2", 32'(words_written), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
